dct_butterfly_mac: RTL

Parametrised butterfly-and-dot-product stage for the DCT datapath, generalising the fixed 8-input even-part block. It takes `2*NP` signed samples and forms either the difference or the sum of each mirrored pair (`x[k] ± x[2NP-1-k]`). Each pair result is multiplied by a runtime signed coefficient, and the products are accumulated over `NP` cycles on a single shared multiplier. The sum is scaled by `2^SHIFT` with truncation toward zero, saturated to `DW` bits, and delivered over valid/ready handshakes. It replaces the counter-slot-driven stages between the input reorder buffer and the output transpose.

---
 rtl/dct_butterfly_mac.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dct_butterfly_mac.sv
// Mirrored-pair butterfly feeding a serial dot product on one shared multiplier,
// followed by truncate-toward-zero scaling, saturation and valid/ready handshakes.
module dct_butterfly_mac #(
  parameter int DW    = 24,
  parameter int NP    = 4,
  parameter int CW    = 16,
  parameter int SHIFT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [2*NP*DW-1:0] x,
  input  logic [NP*CW-1:0]   coef,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      y,
  output logic               sat
);

  localparam int AW = DW + 1 + CW + $clog2(NP);
  localparam int PW = DW + 1 + CW;
  localparam int KW = (NP > 1) ? $clog2(NP) : 1;
  localparam int IW = $clog2(2 * NP);
  localparam logic signed [AW-1:0] Y_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_SCALE = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t               r_state;
  logic [2*NP*DW-1:0]   r_x;
  logic [NP*CW-1:0]     r_coef;
  logic                 r_mode;
  logic signed [AW-1:0] r_acc;
  logic [KW-1:0]        r_k;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [DW-1:0]        r_y;
  logic                 r_sat;

  logic signed [DW-1:0] w_xv [2*NP];
  logic signed [CW-1:0] w_cv [NP];
  logic [IW-1:0]        w_lo_idx;
  logic [IW-1:0]        w_hi_idx;
  logic signed [DW-1:0] w_xa;
  logic signed [DW-1:0] w_xb;
  logic signed [DW:0]   w_pair;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_prod_ext;
  logic                 w_neg;
  logic signed [AW-1:0] w_mag;
  logic signed [AW-1:0] w_shr;
  logic signed [AW-1:0] w_r;
  logic [DW-1:0]        w_y_next;
  logic                 w_sat_next;

  for (genvar g = 0; g < 2*NP; g++) begin : g_xv
    assign w_xv[g] = r_x[g*DW +: DW];
  end
  for (genvar g = 0; g < NP; g++) begin : g_cv
    assign w_cv[g] = r_coef[g*CW +: CW];
  end

  // Pair k with its mirror 2NP-1-k; the extra bit keeps sum/difference exact.
  assign w_lo_idx   = IW'(r_k);
  assign w_hi_idx   = IW'(2*NP-1) - IW'(r_k);
  assign w_xa       = w_xv[w_lo_idx];
  assign w_xb       = w_xv[w_hi_idx];
  assign w_pair     = r_mode ? ($signed({w_xa[DW-1], w_xa}) + $signed({w_xb[DW-1], w_xb}))
                             : ($signed({w_xa[DW-1], w_xa}) - $signed({w_xb[DW-1], w_xb}));
  assign w_prod     = w_pair * w_cv[r_k];
  assign w_prod_ext = AW'(w_prod);

  // Shift the magnitude so negative results round toward zero like the old divider.
  assign w_neg = r_acc[AW-1];
  assign w_mag = w_neg ? -r_acc : r_acc;
  assign w_shr = w_mag >>> SHIFT;
  assign w_r   = w_neg ? -w_shr : w_shr;

  // Clip the scaled value into the DW-bit output range and flag it.
  always_comb begin
    w_y_next   = w_r[DW-1:0];
    w_sat_next = 1'b0;
    if (w_r > Y_MAX) begin
      w_y_next   = {1'b0, {(DW-1){1'b1}}};
      w_sat_next = 1'b1;
    end else if (w_r < Y_MIN) begin
      w_y_next   = {1'b1, {(DW-1){1'b0}}};
      w_sat_next = 1'b1;
    end else begin
      w_y_next   = w_r[DW-1:0];
      w_sat_next = 1'b0;
    end
  end

  // Control FSM with operand capture, accumulation and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_coef      <= '0;
      r_mode      <= 1'b0;
      r_acc       <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_sat       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_x        <= x;
            r_coef     <= coef;
            r_mode     <= mode;
            r_acc      <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_ACC;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_ACC: begin
          r_acc <= r_acc + w_prod_ext;
          if (r_k == KW'(NP-1)) begin
            r_state <= S_SCALE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_SCALE: begin
          r_y         <= w_y_next;
          r_sat       <= w_sat_next;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign sat       = r_sat;

endmodule
